loong_frame_loader: RTL and testbench

LOONG_FRAME_LOADER -- requirements
Module: loong_frame_loader

---
 rtl/loong_frame_loader.sv | 134 +++++++++++++
 tb/tb_loong_frame_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loong_frame_loader.sv
// rtl/loong_frame_loader.sv - UART frame loader feeding the LOONG cipher core
//
// Collects one frame (SOF_BYTE, NIBBLES data bytes, EOF_BYTE) from a byte
// strobe interface into shadow registers.  Once the core is idle it commits
// them to plaintext/round_key and issues a single do_loong start pulse.
//
// Ports:
//   clck       - clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   rx_valid   - one-cycle strobe qualifying rx_byte
//   rx_byte    - received byte; low nibble -> plaintext, high nibble -> key
//   core_busy  - cipher core still working on the previous block
//   plaintext  - committed plaintext, nibble i at [4i+3:4i]
//   round_key  - committed key, same packing
//   do_loong   - one-cycle start pulse to the core
//   frame_err  - one-cycle pulse on a bad EOF marker or inter-byte timeout
//   busy       - high whenever the loader is not idle
module loong_frame_loader #(
  parameter int          NIBBLES        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'hAA,
  parameter logic [7:0]  EOF_BYTE       = 8'hFF,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                   clck,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   core_busy,
  output logic [4*NIBBLES-1:0]   plaintext,
  output logic [4*NIBBLES-1:0]   round_key,
  output logic                   do_loong,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_EOF,
    FIRE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [TO_W-1:0]      to_cnt;
  logic [4*NIBBLES-1:0] shadow_pt;
  logic [4*NIBBLES-1:0] shadow_key;
  logic                 timeout;

  // A byte arriving on the terminal count wins over the timeout.
  assign timeout = (to_cnt == TO_LAST) && !rx_valid;
  assign busy    = (state != IDLE);

  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      to_cnt     <= '0;
      shadow_pt  <= '0;
      shadow_key <= '0;
      plaintext  <= '0;
      round_key  <= '0;
      do_loong   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      do_loong  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_byte == SOF_BYTE) begin
            idx    <= '0;
            to_cnt <= '0;
            state  <= LOAD;
          end
        end

        LOAD: begin
          // Marker values are plain data here; only the count ends LOAD.
          if (rx_valid) begin
            for (int i = 0; i < NIBBLES; i++) begin
              if (idx == IDX_W'(i)) begin
                shadow_pt[4*i +: 4]  <= rx_byte[3:0];
                shadow_key[4*i +: 4] <= rx_byte[7:4];
              end
            end
            idx    <= idx + 1'b1;
            to_cnt <= '0;
            if (idx == LAST_IDX) state <= WAIT_EOF;
          end else if (timeout) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WAIT_EOF: begin
          if (rx_valid) begin
            to_cnt <= '0;
            if (rx_byte == EOF_BYTE) begin
              state <= FIRE;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (timeout) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        FIRE: begin
          // rx_valid is ignored here, including on the exit edge, so a byte
          // coinciding with the commit is never taken as a SOF.
          if (!core_busy) begin
            plaintext <= shadow_pt;
            round_key <= shadow_key;
            do_loong  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loong_frame_loader.sv
// tb/tb_loong_frame_loader.sv - scoreboard bench for loong_frame_loader
module tb_loong_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx_valid [3];
  logic [7:0] rx_byte  [3];
  logic       core_busy[3];

  logic [63:0]  pt_a, key_a;
  logic [3:0]   pt_b, key_b;
  logic [127:0] pt_c, key_c;
  logic         dl_a, fe_a, bz_a, dl_b, fe_b, bz_b, dl_c, fe_c, bz_c;

  loong_frame_loader #(.NIBBLES(16), .TIMEOUT_CYCLES(50)) u_a (
    .clck(clk), .reset(reset), .rx_valid(rx_valid[0]), .rx_byte(rx_byte[0]),
    .core_busy(core_busy[0]), .plaintext(pt_a), .round_key(key_a),
    .do_loong(dl_a), .frame_err(fe_a), .busy(bz_a));

  loong_frame_loader #(.NIBBLES(1)) u_b (
    .clck(clk), .reset(reset), .rx_valid(rx_valid[1]), .rx_byte(rx_byte[1]),
    .core_busy(core_busy[1]), .plaintext(pt_b), .round_key(key_b),
    .do_loong(dl_b), .frame_err(fe_b), .busy(bz_b));

  loong_frame_loader #(.NIBBLES(32)) u_c (
    .clck(clk), .reset(reset), .rx_valid(rx_valid[2]), .rx_byte(rx_byte[2]),
    .core_busy(core_busy[2]), .plaintext(pt_c), .round_key(key_c),
    .do_loong(dl_c), .frame_err(fe_c), .busy(bz_c));

  typedef struct {
    bit           err;
    logic [127:0] pt;
    logic [127:0] key;
    longint       cyc;   // -1: arrival cycle not checked
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  logic [127:0] last_pt [3];
  logic [127:0] last_key[3];

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int u, input bit err, input logic [127:0] pt,
                      input logic [127:0] key, input longint c);
    ev_t e;
    e.err = err;
    e.pt  = err ? last_pt[u]  : pt;
    e.key = err ? last_key[u] : key;
    e.cyc = c;
    if (!err) begin
      last_pt[u]  = pt;
      last_key[u] = key;
    end
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int u, input logic dl, input logic fe,
                     input logic [127:0] pt, input logic [127:0] key);
    ev_t e;
    bit  have;
    if (!(dl || fe)) return;
    chk($sformatf("u%0d_pulse_exclusive", u), 128'(dl & fe), 128'(0));
    have = 1'b0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d_unexpected_pulse actual do_loong=%0d frame_err=%0d required none", u, dl, fe);
      return;
    end
    chk($sformatf("u%0d_kind_is_err", u), 128'(fe), 128'(e.err));
    chk($sformatf("u%0d_plaintext", u), pt, e.pt);
    chk($sformatf("u%0d_round_key", u), key, e.key);
    if (e.cyc >= 0) chk($sformatf("u%0d_pulse_cycle", u), 128'(cyc), 128'(e.cyc));
  endtask

  always @(negedge clk) begin
    mon(0, dl_a, fe_a, 128'(pt_a), 128'(key_a));
    mon(1, dl_b, fe_b, 128'(pt_b), 128'(key_b));
    mon(2, dl_c, fe_c, pt_c, key_c);
  end

  task automatic send(input int u, input logic [7:0] b);
    rx_valid[u] = 1'b1;
    rx_byte[u]  = b;
    @(posedge clk);
    #1;
    rx_valid[u] = 1'b0;
  endtask

  task automatic send_frame(input int u, input int n, input logic [255:0] data,
                            input logic [7:0] eof);
    send(u, 8'hAA);
    for (int i = 0; i < n; i++) send(u, data[8*i +: 8]);
    send(u, eof);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] d;
    logic [127:0] ept, ekey;
    longint       mark;

    reset = 1'b0;
    for (int u = 0; u < 3; u++) begin
      rx_valid[u] = 1'b0; rx_byte[u] = 8'h00; core_busy[u] = 1'b0;
      last_pt[u] = '0; last_key[u] = '0;
    end
    idle(3);

    // Reset state
    chk("rst_pt_a", 128'(pt_a), 0);
    chk("rst_key_a", 128'(key_a), 0);
    chk("rst_busy_a", 128'(bz_a), 0);
    chk("rst_do_a", 128'(dl_a), 0);
    chk("rst_err_a", 128'(fe_a), 0);
    chk("rst_pt_c", pt_c, 0);
    chk("rst_busy_b", 128'(bz_b), 0);
    reset = 1'b1;
    idle(2);

    // Good frame: 10..1F then FF
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'h10 + 8'(i);
    push(0, 0, 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210,
               128'h0000_0000_0000_0000_1111_1111_1111_1111, -1);
    send(0, 8'hAA);
    chk("busy_in_load", 128'(bz_a), 1);
    for (int i = 0; i < 16; i++) send(0, d[8*i +: 8]);
    send(0, 8'hFF);
    idle(3);
    chk("busy_after_good", 128'(bz_a), 0);

    // Bad EOF
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'h20 + 8'(i);
    push(0, 1, '0, '0, -1);
    send_frame(0, 16, d, 8'h55);
    idle(3);
    chk("busy_after_bad_eof", 128'(bz_a), 0);
    chk("pt_kept_after_bad_eof", 128'(pt_a), 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210);

    // Timeout after 3 data bytes, then a fresh frame
    send(0, 8'hAA);
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    push(0, 1, '0, '0, cyc + 50);
    idle(60);
    chk("busy_after_timeout", 128'(bz_a), 0);
    for (int i = 0; i < 16; i++) d[8*i +: 8] = {~4'(i), 4'(i)};
    push(0, 0, 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210,
               128'h0000_0000_0000_0000_0123_4567_89AB_CDEF, -1);
    send_frame(0, 16, d, 8'hFF);
    idle(3);

    // Backpressure: core_busy high for 20 cycles across EOF
    for (int i = 0; i < 16; i++) d[8*i +: 8] = {4'(i), ~4'(i)};
    send(0, 8'hAA);
    for (int i = 0; i < 16; i++) send(0, d[8*i +: 8]);
    core_busy[0] = 1'b1;
    send(0, 8'hFF);
    idle(19);
    chk("bp_pt_unchanged", 128'(pt_a), 128'h0000_0000_0000_0000_FEDC_BA98_7654_3210);
    chk("bp_busy_in_fire", 128'(bz_a), 1);
    // Release the core and present an AA on the commit edge: must be ignored
    core_busy[0] = 1'b0;
    mark = cyc;
    push(0, 0, 128'h0000_0000_0000_0000_0123_4567_89AB_CDEF,
               128'h0000_0000_0000_0000_FEDC_BA98_7654_3210, mark + 1);
    send(0, 8'hAA);
    idle(2);
    chk("sof_on_fire_exit_ignored", 128'(bz_a), 0);

    // Markers as data
    d = '0;
    d[7:0] = 8'hAA;
    d[15:8] = 8'hFF;
    push(0, 0, 128'h00FA, 128'h00FA, -1);
    send_frame(0, 16, d, 8'hFF);
    idle(3);

    // Mid-frame reset at nibble 7
    send(0, 8'hAA);
    for (int i = 0; i < 7; i++) send(0, 8'h33);
    reset = 1'b0;
    #1;
    chk("mid_rst_pt", 128'(pt_a), 0);
    chk("mid_rst_key", 128'(key_a), 0);
    chk("mid_rst_busy", 128'(bz_a), 0);
    for (int u = 0; u < 3; u++) begin last_pt[u] = '0; last_key[u] = '0; end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 8'h11);
    send(0, 8'hFF);
    idle(2);
    chk("ignored_without_sof", 128'(bz_a), 0);
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'h12;
    push(0, 0, 128'h2222_2222_2222_2222, 128'h1111_1111_1111_1111, -1);
    send_frame(0, 16, d, 8'hFF);
    idle(3);

    // Parameter sweep: NIBBLES=1 and NIBBLES=32 with random data
    for (int f = 0; f < 3; f++) begin
      d = '0; ept = '0; ekey = '0;
      d[7:0] = 8'($urandom);
      ept[3:0] = d[3:0];
      ekey[3:0] = d[7:4];
      push(1, 0, ept, ekey, -1);
      send_frame(1, 1, d, 8'hFF);
      idle(3);
    end
    for (int f = 0; f < 3; f++) begin
      ept = '0; ekey = '0;
      for (int i = 0; i < 32; i++) begin
        d[8*i +: 8] = 8'($urandom);
        ept[4*i +: 4] = d[8*i +: 4];
        ekey[4*i +: 4] = d[8*i+4 +: 4];
      end
      push(2, 0, ept, ekey, -1);
      send_frame(2, 32, d, 8'hFF);
      idle(3);
    end

    idle(5);
    chk("u0_pending_events", 128'(q0.size()), 0);
    chk("u1_pending_events", 128'(q1.size()), 0);
    chk("u2_pending_events", 128'(q2.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
